// File: rtl/shadow_fetch_arbiter_if.sv
// Requester/ROM-side bundle for the shadow fetch arbiter. The master side holds
// the fighters, the frame pulse and the ROM data return. The slave side is the arbiter.
interface shadow_fetch_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 4
);
   logic              frame_start;
   logic              reqL;
   logic [ADDR_W-1:0] addrL;
   logic              reqR;
   logic [ADDR_W-1:0] addrR;
   logic [DATA_W-1:0] rom_data;
   logic [ADDR_W-1:0] rom_addr;
   logic              grantL;
   logic              grantR;
   logic              validL;
   logic              validR;
   logic [DATA_W-1:0] dataL;
   logic [DATA_W-1:0] dataR;
   logic              busy;

   modport master (
      output frame_start, reqL, addrL, reqR, addrR, rom_data,
      input  rom_addr, grantL, grantR, validL, validR, dataL, dataR, busy
   );

   modport slave (
      input  frame_start, reqL, addrL, reqR, addrR, rom_data,
      output rom_addr, grantL, grantR, validL, validR, dataL, dataR, busy
   );
endinterface

// File: rtl/shadow_fetch_arbiter.sv
// Round-robin arbiter sharing one shadow-sprite ROM between two fighters.
// It grants one fetch per cycle and steers each return to its requester by a tag, in grant order.
module shadow_fetch_arbiter #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 4,
   parameter int ROM_LAT = 2
) (
   input  logic                  clk_25MHz,
   input  logic                  reset_n,
   shadow_fetch_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_L = 2'd1,
      SERVE_R = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_r_q, last_r_d;
   logic                pick_l, pick_r;
   logic [ADDR_W-1:0]   rom_addr_q;
   // Stage 0 is loaded with the grant, stage ROM_LAT is the return strobe; tag 1 means R
   logic [ROM_LAT:0]    vld_q, tag_q;
   logic [DATA_W-1:0]   dataL_q, dataR_q;

   always_comb begin
      pick_l   = bus.reqL & (~bus.reqR | last_r_q);
      pick_r   = bus.reqR & ~pick_l;
      state_d  = IDLE;
      if (pick_l)      state_d = SERVE_L;
      else if (pick_r) state_d = SERVE_R;
      // Frame start resets fairness so L wins the first tie of the new frame
      last_r_d = last_r_q;
      if (bus.frame_start) last_r_d = 1'b1;
      else if (pick_l)     last_r_d = 1'b0;
      else if (pick_r)     last_r_d = 1'b1;
   end

   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_r_q   <= 1'b1;
         rom_addr_q <= '0;
         vld_q      <= '0;
         tag_q      <= '0;
         dataL_q    <= '0;
         dataR_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_r_q <= last_r_d;
         if (pick_l)      rom_addr_q <= bus.addrL;
         else if (pick_r) rom_addr_q <= bus.addrR;
         vld_q[0] <= pick_l | pick_r;
         tag_q[0] <= pick_r;
         for (int i = 1; i <= ROM_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
         if (vld_q[ROM_LAT-1] & ~tag_q[ROM_LAT-1]) dataL_q <= bus.rom_data;
         if (vld_q[ROM_LAT-1] &  tag_q[ROM_LAT-1]) dataR_q <= bus.rom_data;
      end
   end

   assign bus.rom_addr = rom_addr_q;
   assign bus.grantL   = (state_q == SERVE_L);
   assign bus.grantR   = (state_q == SERVE_R);
   assign bus.validL   = vld_q[ROM_LAT] & ~tag_q[ROM_LAT];
   assign bus.validR   = vld_q[ROM_LAT] &  tag_q[ROM_LAT];
   assign bus.dataL    = dataL_q;
   assign bus.dataR    = dataR_q;
   assign bus.busy     = |vld_q;

   assert property (@(posedge clk_25MHz) disable iff (!reset_n) !(bus.grantL && bus.grantR));
   assert property (@(posedge clk_25MHz) disable iff (!reset_n) !(bus.validL && bus.validR));
endmodule
